game_control: RTL and testbench

Top-level sequencing FSM for the game loop; the direct upstream stage of the datapath. Drives the datapath's one-hot phase strobes (`init`, `idle`, `gen_move`, `check_collide`, `apply_act_link`, `move_enemies`, `draw_map`, `draw_link`, `draw_enemies`) and advances on the datapath's done signals. It produces one frame per loop and counts frames. It adds a pause input and an optional watchdog that recovers from a hung phase.

---
 rtl/game_control_if.sv | 41 ++++
 rtl/game_control.sv | 126 ++++++++++++
 tb/tb_game_control.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_control_if.sv
// game_control_if: phase strobes, done inputs, pause and status between
// the game sequencer (master) and the datapath (slave).
interface game_control_if #(
    parameter int FRAME_W = 16
);
    logic               c_pause;
    logic               idle_done;
    logic               gen_move_done;
    logic               check_collide_done;
    logic               draw_map_done;
    logic               draw_link_done;
    logic               draw_enemies_done;
    logic               init;
    logic               idle;
    logic               gen_move;
    logic               check_collide;
    logic               apply_act_link;
    logic               move_enemies;
    logic               draw_map;
    logic               draw_link;
    logic               draw_enemies;
    logic [3:0]         state;
    logic [FRAME_W-1:0] frame_count;
    logic               wdog_fault;

    modport master (
        input  c_pause, idle_done, gen_move_done, check_collide_done,
               draw_map_done, draw_link_done, draw_enemies_done,
        output init, idle, gen_move, check_collide, apply_act_link,
               move_enemies, draw_map, draw_link, draw_enemies,
               state, frame_count, wdog_fault
    );

    modport slave (
        output c_pause, idle_done, gen_move_done, check_collide_done,
               draw_map_done, draw_link_done, draw_enemies_done,
        input  init, idle, gen_move, check_collide, apply_act_link,
               move_enemies, draw_map, draw_link, draw_enemies,
               state, frame_count, wdog_fault
    );
endinterface

// File: rtl/game_control.sv
// game_control: sequencing FSM for the game loop. Drives one-hot phase
// strobes to the datapath, advances on its done inputs, counts frames and
// supports pausing in IDLE.
// Optional watchdog: define GAME_CONTROL_WDOG_EN to build a per-state
// timeout that forces a hung wait state onward and sets a sticky fault.
module game_control #(
    parameter int                FRAME_W     = 16,
    parameter int                WDOG_W      = 22,
    parameter logic [WDOG_W-1:0] WDOG_CYCLES = 22'd3000000
) (
    input  logic          clock,
    input  logic          reset,
    game_control_if.master gc
);

    typedef enum logic [3:0] {
        S_INIT           = 4'd0,
        S_IDLE           = 4'd1,
        S_GEN_MOVE       = 4'd2,
        S_CHECK_COLLIDE  = 4'd3,
        S_APPLY_ACT_LINK = 4'd4,
        S_MOVE_ENEMIES   = 4'd5,
        S_DRAW_MAP       = 4'd6,
        S_DRAW_LINK      = 4'd7,
        S_DRAW_ENEMIES   = 4'd8
    } state_t;

    state_t             state_q, state_d;
    state_t             nxt;
    logic [8:0]         strobe_q, strobe_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               fault_q, fault_d;
    logic               go;
    logic               wait_st;
    logic               timeout;

`ifdef GAME_CONTROL_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_CYCLES - 1'b1;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
    logic unused_wdog;
    assign unused_wdog = ^{wait_st, WDOG_CYCLES};
`endif

    // Successor of each state and the condition that releases it; only the
    // current state's own done input is consulted.
    always_comb begin
        nxt     = S_INIT;
        go      = 1'b0;
        wait_st = 1'b0;
        case (state_q)
            S_INIT:           begin nxt = S_DRAW_MAP;      go = 1'b1; end
            S_IDLE:           begin nxt = S_GEN_MOVE;      go = gc.idle_done & ~gc.c_pause; end
            S_GEN_MOVE:       begin nxt = S_CHECK_COLLIDE; go = gc.gen_move_done;      wait_st = 1'b1; end
            S_CHECK_COLLIDE:  begin nxt = S_APPLY_ACT_LINK; go = gc.check_collide_done; wait_st = 1'b1; end
            S_APPLY_ACT_LINK: begin nxt = S_MOVE_ENEMIES;  go = 1'b1; end
            S_MOVE_ENEMIES:   begin nxt = S_DRAW_MAP;      go = 1'b1; end
            S_DRAW_MAP:       begin nxt = S_DRAW_LINK;     go = gc.draw_map_done;      wait_st = 1'b1; end
            S_DRAW_LINK:      begin nxt = S_DRAW_ENEMIES;  go = gc.draw_link_done;     wait_st = 1'b1; end
            S_DRAW_ENEMIES:   begin nxt = S_IDLE;          go = gc.draw_enemies_done;  wait_st = 1'b1; end
            default:          begin nxt = S_INIT;          go = 1'b1; end
        endcase
    end

    // Watchdog, state advance, frame counter and the registered strobe decode.
    always_comb begin
`ifdef GAME_CONTROL_WDOG_EN
        // A real done on the timeout cycle wins, so no fault in that case.
        timeout = wait_st & ~go & (wdog_q == WDOG_LAST);
        if (go || timeout || !wait_st) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
        fault_d = fault_q | timeout;
`else
        timeout = 1'b0;
        fault_d = 1'b0;
`endif
        state_d = (go || timeout) ? nxt : state_q;
        frame_d = frame_q;
        if (state_q == S_DRAW_ENEMIES && (go || timeout)) begin
            frame_d = frame_q + 1'b1;
        end
        // state_d is always a legal code, so exactly one strobe is set.
        strobe_d = '0;
        for (int i = 0; i < 9; i++) begin
            strobe_d[i] = (state_d == state_t'(4'(i)));
        end
    end

    // All control state; reset drops straight back to INIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_INIT;
            strobe_q <= 9'b0_0000_0001;
            frame_q  <= '0;
            fault_q  <= 1'b0;
`ifdef GAME_CONTROL_WDOG_EN
            wdog_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            frame_q  <= frame_d;
            fault_q  <= fault_d;
`ifdef GAME_CONTROL_WDOG_EN
            wdog_q   <= wdog_d;
`endif
        end
    end

    assign gc.init           = strobe_q[0];
    assign gc.idle           = strobe_q[1];
    assign gc.gen_move       = strobe_q[2];
    assign gc.check_collide  = strobe_q[3];
    assign gc.apply_act_link = strobe_q[4];
    assign gc.move_enemies   = strobe_q[5];
    assign gc.draw_map       = strobe_q[6];
    assign gc.draw_link      = strobe_q[7];
    assign gc.draw_enemies   = strobe_q[8];
    assign gc.state          = state_q;
    assign gc.frame_count    = frame_q;
    assign gc.wdog_fault     = fault_q;

endmodule

// File: tb/tb_game_control.sv
// tb_game_control: directed test of the game sequencer. A 4-bit frame
// counter keeps the wrap test short; the watchdog timeout is 16 clocks.
module tb_game_control;

    localparam int FRAME_W = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    game_control_if #(.FRAME_W(FRAME_W)) gc ();

    game_control #(
        .FRAME_W    (FRAME_W),
        .WDOG_W     (22),
        .WDOG_CYCLES(22'd16)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .gc   (gc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {23'd0, gc.draw_enemies, gc.draw_link, gc.draw_map, gc.move_enemies,
                gc.apply_act_link, gc.check_collide, gc.gen_move, gc.idle, gc.init};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input logic [3:0] exp);
        chk("state", {28'd0, gc.state}, {28'd0, exp});
        chk("strobes", strobes(), 32'd1 << exp);
    endtask

    task automatic set_done(input logic [3:0] st, input logic v);
        case (st)
            4'd1: gc.idle_done          = v;
            4'd2: gc.gen_move_done      = v;
            4'd3: gc.check_collide_done = v;
            4'd6: gc.draw_map_done      = v;
            4'd7: gc.draw_link_done     = v;
            4'd8: gc.draw_enemies_done  = v;
            default: ;
        endcase
    endtask

    task automatic all_done(input logic v);
        gc.idle_done          = v;
        gc.gen_move_done      = v;
        gc.check_collide_done = v;
        gc.draw_map_done      = v;
        gc.draw_link_done     = v;
        gc.draw_enemies_done  = v;
    endtask

    // Stay in st for n cycles, then pulse its done for one cycle.
    task automatic pulse_after(input logic [3:0] st, input int n);
        repeat (n) begin
            chk_state(st);
            step();
        end
        set_done(st, 1'b1);
        step();
        set_done(st, 1'b0);
    endtask

    initial begin
        logic [3:0] seq_a [6];
        logic [3:0] seq_b [8];
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        gc.c_pause = 1'b0;
        all_done(1'b0);
        seq_a = '{4'd6, 4'd7, 4'd8, 4'd1, 4'd2, 4'd3};
        seq_b = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd1};

        // Reset held for 5 clocks, then first frame starts at DRAW_MAP
        repeat (5) step();
        chk_state(4'd0);
        chk("frame_rst", 32'(gc.frame_count), 32'd0);
        chk("fault_rst", 32'(gc.wdog_fault), 32'd0);
        rst_n = 1'b1;
        step();
        chk_state(4'd6);
        chk("frame_first", 32'(gc.frame_count), 32'd0);

        // Full loop with done pulses 3 clocks after entry
        for (int i = 0; i < 6; i++) begin
            chk_state(seq_a[i]);
            if (seq_a[i] == 4'd1) chk("frame_loop1", 32'(gc.frame_count), 32'd1);
            pulse_after(seq_a[i], 3);
        end
        chk_state(4'd4);
        step();
        chk_state(4'd5);
        step();
        chk_state(4'd6);
        chk("frame_pre_idle", 32'(gc.frame_count), 32'd1);

        // Finish frame 2 and reach IDLE
        pulse_after(4'd6, 1);
        pulse_after(4'd7, 1);
        pulse_after(4'd8, 1);
        chk_state(4'd1);
        chk("frame_2", 32'(gc.frame_count), 32'd2);

        // Pause discards idle_done pulses
        gc.c_pause = 1'b1;
        repeat (3) begin
            gc.idle_done = 1'b1;
            step();
            gc.idle_done = 1'b0;
            step();
            chk_state(4'd1);
        end
        gc.c_pause = 1'b0;
        pulse_after(4'd1, 0);
        chk_state(4'd2);

        // Stale draw_map_done held high must not skip DRAW_LINK
        pulse_after(4'd2, 1);
        pulse_after(4'd3, 1);
        chk_state(4'd4);
        step();
        step();
        chk_state(4'd6);
        gc.draw_map_done = 1'b1;
        step();
        repeat (5) begin
            chk_state(4'd7);
            step();
        end
        chk_state(4'd7);
        pulse_after(4'd7, 0);
        chk_state(4'd8);
        pulse_after(4'd8, 0);
        gc.draw_map_done = 1'b0;
        chk_state(4'd1);
        chk("frame_3", 32'(gc.frame_count), 32'd3);

        // Reset asserted in DRAW_LINK takes effect without a clock edge
        pulse_after(4'd1, 0);
        pulse_after(4'd2, 0);
        pulse_after(4'd3, 0);
        step();
        step();
        pulse_after(4'd6, 0);
        chk_state(4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_init", 32'(gc.init), 32'd1);
        chk("async_draw_link", 32'(gc.draw_link), 32'd0);
        chk("async_state", 32'(gc.state), 32'd0);
        chk("async_frame", 32'(gc.frame_count), 32'd0);
        repeat (2) step();
        chk_state(4'd0);
        rst_n = 1'b1;
        step();
        chk_state(4'd6);

        // Minimum loop with every done held high: IDLE to IDLE in 8 clocks
        all_done(1'b1);
        step();
        chk_state(4'd7);
        step();
        chk_state(4'd8);
        step();
        chk_state(4'd1);
        chk("frame_min0", 32'(gc.frame_count), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_state(seq_b[i]);
        end
        chk("frame_min1", 32'(gc.frame_count), 32'd2);

        // Run to all-ones, then one more frame wraps to 0
        repeat (13 * 8) step();
        chk_state(4'd1);
        chk("frame_max", 32'(gc.frame_count), 32'd15);
        repeat (8) step();
        chk_state(4'd1);
        chk("frame_wrap", 32'(gc.frame_count), 32'd0);
        all_done(1'b0);

        // Hung GEN_MOVE
        pulse_after(4'd1, 1);
        chk_state(4'd2);
        chk("fault_pre", 32'(gc.wdog_fault), 32'd0);
`ifdef GAME_CONTROL_WDOG_EN
        repeat (15) begin
            step();
            chk_state(4'd2);
        end
        step();
        chk_state(4'd3);
        chk("wdog_fault_set", 32'(gc.wdog_fault), 32'd1);
        pulse_after(4'd3, 0);
        chk_state(4'd4);
        chk("wdog_fault_sticky", 32'(gc.wdog_fault), 32'd1);

        // Done on the timeout cycle is a normal exit; forced DRAW_ENEMIES still counts
        rst_n = 1'b0;
        step();
        chk("wdog_fault_clr", 32'(gc.wdog_fault), 32'd0);
        rst_n = 1'b1;
        step();
        repeat (15) begin
            chk_state(4'd6);
            step();
        end
        chk_state(4'd6);
        pulse_after(4'd6, 0);
        chk_state(4'd7);
        chk("wdog_same_cycle", 32'(gc.wdog_fault), 32'd0);
        pulse_after(4'd7, 1);
        repeat (15) begin
            chk_state(4'd8);
            step();
        end
        chk_state(4'd8);
        step();
        chk_state(4'd1);
        chk("wdog_forced_frame", 32'(gc.frame_count), 32'd1);
        chk("wdog_forced_fault", 32'(gc.wdog_fault), 32'd1);
`else
        repeat (40) step();
        chk_state(4'd2);
        chk("no_wdog_fault", 32'(gc.wdog_fault), 32'd0);
        chk("no_wdog_frame", 32'(gc.frame_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
